panel_input: RTL and testbench



---
 rtl/panel_input.sv | 128 ++++++++++++
 tb/tb_panel_input.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/panel_input.sv
// Front-panel input conditioner: 2-flop synchronizers, per-bit debounce, HALT/RUN/STEP clock-enable FSM.
// Optional PANEL_STEP_COUNTER_EN builds the step_count register; otherwise step_count is tied to 0.
module panel_input #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_step_raw,
  input  logic             btn_run_raw,
  output logic [WIDTH-1:0] port_out,
  output logic             cpu_en,
  output logic             run_mode,
  output logic [WIDTH-1:0] step_count
);

  localparam int unsigned NumIn = WIDTH + 2;
  // Counter value on which the next differing cycle completes the debounce window.
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StHalt, StStep, StRun} state_e;

  logic [NumIn-1:0]     raw;
  logic [NumIn-1:0]     s1_q, s2_q;
  logic [NumIn-1:0]     stable_q, stable_d;
  logic [CNT_WIDTH-1:0] cnt_q [NumIn];
  logic [CNT_WIDTH-1:0] cnt_d [NumIn];
  logic [1:0]           btn_db, btn_q, btn_press;
  state_e               state_q;
  logic                 cpu_en_q, run_mode_q;

  assign raw = {btn_run_raw, btn_step_raw, sw_raw};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NumIn); i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      btn_q    <= '0;
      for (int i = 0; i < int'(NumIn); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      btn_q    <= btn_db;
      for (int i = 0; i < int'(NumIn); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Bit 0 is STEP, bit 1 is RUN.
  assign btn_db    = stable_q[NumIn-1:WIDTH];
  assign btn_press = btn_db & ~btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHalt;
      cpu_en_q   <= 1'b0;
      run_mode_q <= 1'b0;
    end else begin
      case (state_q)
        StHalt: begin
          if (btn_press[1]) begin
            state_q    <= StRun;
            cpu_en_q   <= 1'b1;
            run_mode_q <= 1'b1;
          end else if (btn_press[0]) begin
            state_q    <= StStep;
            cpu_en_q   <= 1'b1;
            run_mode_q <= 1'b0;
          end
        end
        StRun: begin
          if (btn_press[1]) begin
            state_q    <= StHalt;
            cpu_en_q   <= 1'b0;
            run_mode_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StHalt;
          cpu_en_q   <= 1'b0;
          run_mode_q <= 1'b0;
        end
      endcase
    end
  end

  assign port_out = stable_q[WIDTH-1:0];
  assign cpu_en   = cpu_en_q;
  assign run_mode = run_mode_q;

`ifdef PANEL_STEP_COUNTER_EN
  logic [WIDTH-1:0] step_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_count_q <= '0;
    end else if (cpu_en_q) begin
      step_count_q <= step_count_q + 1'b1;
    end
  end

  assign step_count = step_count_q;
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_panel_input.sv
// Scoreboard bench for panel_input with DEBOUNCE_CYCLES=4: expectations are queued per cycle,
// a negedge monitor pops and compares them.
module tb_panel_input;

  localparam int unsigned Width = 8;

  logic             clk;
  logic             rst;
  logic [Width-1:0] sw_raw;
  logic             btn_step_raw;
  logic             btn_run_raw;
  logic [Width-1:0] port_out;
  logic             cpu_en;
  logic             run_mode;
  logic [Width-1:0] step_count;

  panel_input #(
    .WIDTH          (Width),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .btn_step_raw(btn_step_raw),
    .btn_run_raw (btn_run_raw),
    .port_out    (port_out),
    .cpu_en      (cpu_en),
    .run_mode    (run_mode),
    .step_count  (step_count)
  );

  typedef struct {
    int         at;
    string      name;
    logic [7:0] pout;
    logic       en;
    logic       run;
    logic [7:0] sc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sc(input int n);
`ifdef PANEL_STEP_COUNTER_EN
    return 8'(n);
`else
    return 8'(0 * n);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // Sorted insert so phases may queue expectations out of order.
  task automatic push_exp(input int at, input string name, input logic [7:0] p, input logic en,
                          input logic run, input logic [7:0] s);
    exp_t e;
    int   idx;
    e.at   = at;
    e.name = name;
    e.pout = p;
    e.en   = en;
    e.run  = run;
    e.sc   = s;
    idx    = sb.size();
    while (idx > 0 && sb[idx-1].at > at) idx--;
    sb.insert(idx, e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.at < cyc) begin
          n_bad++;
          $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.at, cyc);
        end else if ({port_out, cpu_en, run_mode, step_count} !== {e.pout, e.en, e.run, e.sc}) begin
          n_bad++;
          $display("FAIL %s @%0d: got port=%h en=%b run=%b cnt=%h, want port=%h en=%b run=%b cnt=%h",
                   e.name, cyc, port_out, cpu_en, run_mode, step_count,
                   e.pout, e.en, e.run, e.sc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (cycle %0d, done=%b)", cyc, done);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, scnt, jw, cr;
    rst          = 1'b1;
    sw_raw       = 8'hFF;
    btn_step_raw = 1'b1;
    btn_run_raw  = 1'b0;

    // Reset with switches and STEP held high.
    repeat (3) tick();
    c = cyc;
    push_exp(c, "reset_outputs", 8'h00, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    push_exp(c + 5, "rst_port_still0", 8'h00, 1'b0, 1'b0, sc(0));
    push_exp(c + 6, "rst_port_ff", 8'hFF, 1'b0, 1'b0, sc(0));
    push_exp(c + 7, "rst_step_pulse", 8'hFF, 1'b1, 1'b0, sc(0));
    push_exp(c + 8, "rst_step_end", 8'hFF, 1'b0, 1'b0, sc(1));
    push_exp(c + 12, "rst_step_once", 8'hFF, 1'b0, 1'b0, sc(1));
    scnt = 1;
    wait_until(c + 10);
    btn_step_raw = 1'b0;
    wait_until(c + 20);

    // Bounce on switch bit 0.
    c = cyc;
    sw_raw = 8'hFE;
    push_exp(c + 6, "sw_bit0_low", 8'hFE, 1'b0, 1'b0, sc(scnt));
    wait_until(c + 10);
    c1 = cyc;
    for (int i = 0; i < 10; i++) push_exp(c1 + i, "bounce_hold", 8'hFE, 1'b0, 1'b0, sc(scnt));
    push_exp(c1 + 10, "bounce_settle", 8'hFF, 1'b0, 1'b0, sc(scnt));
    sw_raw[0] = 1'b1; tick();
    sw_raw[0] = 1'b0; tick();
    sw_raw[0] = 1'b1; tick();
    sw_raw[0] = 1'b0; tick();
    sw_raw[0] = 1'b1;
    wait_until(c1 + 14);

    // Three clean single steps.
    for (int k = 0; k < 3; k++) begin
      c = cyc;
      btn_step_raw = 1'b1;
      push_exp(c + 6, "step_pre", 8'hFF, 1'b0, 1'b0, sc(scnt));
      push_exp(c + 7, "step_pulse", 8'hFF, 1'b1, 1'b0, sc(scnt));
      push_exp(c + 8, "step_end", 8'hFF, 1'b0, 1'b0, sc(scnt + 1));
      push_exp(c + 9, "step_halted", 8'hFF, 1'b0, 1'b0, sc(scnt + 1));
      scnt++;
      wait_until(c + 10);
      btn_step_raw = 1'b0;
      wait_until(c + 20);
    end

    // RUN toggle, switch change and ignored STEP during RUN.
    c = cyc;
    btn_run_raw = 1'b1;
    push_exp(c + 6, "run_pre", 8'hFF, 1'b0, 1'b0, sc(scnt));
    push_exp(c + 7, "run_enter", 8'hFF, 1'b1, 1'b1, sc(scnt));
    push_exp(c + 25, "run_sw_old", 8'hFF, 1'b1, 1'b1, sc(scnt + 18));
    push_exp(c + 26, "run_sw_new", 8'h5A, 1'b1, 1'b1, sc(scnt + 19));
    push_exp(c + 27, "run_20", 8'h5A, 1'b1, 1'b1, sc(scnt + 20));
    push_exp(c + 38, "run_step_ignored", 8'h5A, 1'b1, 1'b1, sc(scnt + 31));
    push_exp(c + 56, "run_last", 8'h5A, 1'b1, 1'b1, sc(scnt + 49));
    push_exp(c + 57, "run_to_halt", 8'h5A, 1'b0, 1'b0, sc(scnt + 50));
    push_exp(c + 62, "halt_frozen", 8'h5A, 1'b0, 1'b0, sc(scnt + 50));
    wait_until(c + 10);
    btn_run_raw = 1'b0;
    wait_until(c + 20);
    sw_raw = 8'h5A;
    wait_until(c + 30);
    btn_step_raw = 1'b1;
    wait_until(c + 40);
    btn_step_raw = 1'b0;
    wait_until(c + 50);
    btn_run_raw = 1'b1;
    wait_until(c + 60);
    btn_run_raw = 1'b0;
    scnt += 50;
    wait_until(c + 70);

    // Simultaneous presses, then counter wrap and reset during RUN.
    c = cyc;
    btn_step_raw = 1'b1;
    btn_run_raw  = 1'b1;
    jw = 256 - scnt;
    cr = c + 7 + jw + 10;
    push_exp(c + 6, "simul_pre", 8'h5A, 1'b0, 1'b0, sc(scnt));
    push_exp(c + 7, "simul_run_wins", 8'h5A, 1'b1, 1'b1, sc(scnt));
    push_exp(c + 8, "simul_still_run", 8'h5A, 1'b1, 1'b1, sc(scnt + 1));
    push_exp(c + 6 + jw, "wrap_ff", 8'h5A, 1'b1, 1'b1, sc(255));
    push_exp(c + 7 + jw, "wrap_00", 8'h5A, 1'b1, 1'b1, sc(0));
    push_exp(cr, "pre_rst", 8'h5A, 1'b1, 1'b1, sc(10));
    push_exp(cr + 1, "rst_mid_run", 8'h00, 1'b0, 1'b0, 8'h00);
    push_exp(cr + 6, "post_rst_port0", 8'h00, 1'b0, 1'b0, 8'h00);
    push_exp(cr + 7, "post_rst_port", 8'h5A, 1'b0, 1'b0, 8'h00);
    push_exp(cr + 10, "post_rst_halt", 8'h5A, 1'b0, 1'b0, 8'h00);
    wait_until(c + 10);
    btn_step_raw = 1'b0;
    btn_run_raw  = 1'b0;
    wait_until(cr);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_until(cr + 12);

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d never reached", e.name, e.at);
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
